grava_instrucao: RTL and testbench

GRAVA_INSTRUCAO -- requirements
Module: grava_instrucao

---
 rtl/instrucao_pkg.sv | 58 +++++
 rtl/codifica_campos.sv | 57 +++++
 rtl/grava_instrucao.sv | 177 +++++++++++++++++
 tb/tb_grava_instrucao.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instrucao_pkg.sv
// -----------------------------------------------------------------------------
// instrucao_pkg
//   Shared definitions for the instruction-writer slice:
//     - formato_t : encoding of the 2-bit instruction-format selector
//     - estado_t  : states of the grava_instrucao controller
//     - bit positions of every MIPS field inside the 32-bit word
//     - campos_aceitos(): legality test for a field set, used only when the
//       optional FORMATO_CHECK_EN format check is compiled in.
// -----------------------------------------------------------------------------
package instrucao_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_J   = 2'b10,
    FMT_INV = 2'b11
  } formato_t;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,   // waiting for a field set
    ESCREVE = 2'b01,   // assembled word offered to program memory
    CHEIO   = 2'b10    // memory full, parked until reset
  } estado_t;

  // Field bit positions inside the 32-bit instruction word.
  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;
  localparam int RS_MSB   = 25;
  localparam int RS_LSB   = 21;
  localparam int RT_MSB   = 20;
  localparam int RT_LSB   = 16;
  localparam int RD_MSB   = 15;
  localparam int RD_LSB   = 11;
  localparam int SH_MSB   = 10;
  localparam int SH_LSB   = 6;
  localparam int FN_MSB   = 5;
  localparam int FN_LSB   = 0;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;
  localparam int ALVO_MSB = 25;
  localparam int ALVO_LSB = 0;

  // R-format instructions always carry the SPECIAL opcode.
  localparam logic [5:0] OP_SPECIAL = 6'd0;

  // A field set is legal unless the format is the reserved encoding, or it
  // claims R-format with an opcode other than SPECIAL.
  function automatic logic campos_aceitos(input logic [1:0] formato,
                                          input logic [5:0] op_code);
    campos_aceitos = 1'b1;
    if (formato == FMT_INV) begin
      campos_aceitos = 1'b0;
    end else if ((formato == FMT_R) && (op_code != OP_SPECIAL)) begin
      campos_aceitos = 1'b0;
    end
  endfunction

endpackage

// File: rtl/codifica_campos.sv
// -----------------------------------------------------------------------------
// codifica_campos
//   Purely combinational packer: MIPS fields + format selector -> 32-bit word.
//     R : {op, rs, rt, rd, shamt, funct}
//     I : {op, rs, rt, imm16}
//     J : {op, target26}
//   The reserved format encoding is packed like I-format; whether it is
//   accepted at all is decided by the caller.
//
// Ports
//   formato_i   [1:0]  format selector (formato_t encoding)
//   op_code_i   [5:0]  opcode
//   rs_i, rt_i, rd_i, shamt_i [4:0]  register / shift fields
//   funct_i     [5:0]  function code
//   endereco_i  [15:0] immediate / offset
//   alvo_i      [25:0] jump target
//   palavra_o   [31:0] packed instruction
// -----------------------------------------------------------------------------
module codifica_campos
  import instrucao_pkg::*;
(
  input  logic [1:0]  formato_i,
  input  logic [5:0]  op_code_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] endereco_i,
  input  logic [25:0] alvo_i,
  output logic [31:0] palavra_o
);

  always_comb begin
    palavra_o = '0;
    palavra_o[OP_MSB:OP_LSB] = op_code_i;
    case (formato_i)
      FMT_R: begin
        palavra_o[RS_MSB:RS_LSB] = rs_i;
        palavra_o[RT_MSB:RT_LSB] = rt_i;
        palavra_o[RD_MSB:RD_LSB] = rd_i;
        palavra_o[SH_MSB:SH_LSB] = shamt_i;
        palavra_o[FN_MSB:FN_LSB] = funct_i;
      end
      FMT_J: begin
        palavra_o[ALVO_MSB:ALVO_LSB] = alvo_i;
      end
      default: begin
        // I-format, and the reserved encoding packed the same way.
        palavra_o[RS_MSB:RS_LSB]   = rs_i;
        palavra_o[RT_MSB:RT_LSB]   = rt_i;
        palavra_o[IMM_MSB:IMM_LSB] = endereco_i;
      end
    endcase
  end

endmodule

// File: rtl/grava_instrucao.sv
// -----------------------------------------------------------------------------
// grava_instrucao
//   Takes one set of MIPS instruction fields at a time, packs it into a 32-bit
//   word and writes it into program memory at consecutive word addresses,
//   starting at 0. After PROF words the block parks in CHEIO until reset.
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
//   valid and ready are both 1. The producer keeps data stable while valid=1
//   and ready=0. Ready/valid outputs here are registered and never depend
//   combinationally on the partner's signal.
//     fields in : campo_valido / campo_pronto
//     word out  : instr_valido / instr_pronto
//
// Optional feature (macro FORMATO_CHECK_EN): reject the reserved format and
//   R-format with a non-zero opcode, pulsing erro for one cycle and writing
//   nothing. Without the macro every field set is written and erro is 0.
//
// Parameters
//   PROF  program-memory depth in words (power of two, 2..65536)
//   AW    word-address width, $clog2(PROF)
//
// Ports
//   clock, reset          clock (rising edge), synchronous active-high reset
//   campo_valido/pronto   field-set handshake
//   formato, Op_code, Register_rs/rt/rd, Shamt, Funct, Endereco, Alvo : fields
//   instr_valido/pronto   memory-write handshake
//   instrucao [31:0]      assembled word
//   instr_endereco [AW-1:0] word address of instrucao
//   cheio                 all PROF words written
//   erro                  one-cycle pulse on a rejected field set
//   total [AW:0]          number of words written
//   estado_dbg            current controller state, for observation
// -----------------------------------------------------------------------------
module grava_instrucao
  import instrucao_pkg::*;
#(
  parameter int PROF = 256,
  parameter int AW   = $clog2(PROF)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          campo_valido,
  output logic          campo_pronto,
  input  logic [1:0]    formato,
  input  logic [5:0]    Op_code,
  input  logic [4:0]    Register_rs,
  input  logic [4:0]    Register_rt,
  input  logic [4:0]    Register_rd,
  input  logic [4:0]    Shamt,
  input  logic [5:0]    Funct,
  input  logic [15:0]   Endereco,
  input  logic [25:0]   Alvo,
  output logic          instr_valido,
  input  logic          instr_pronto,
  output logic [31:0]   instrucao,
  output logic [AW-1:0] instr_endereco,
  output logic          cheio,
  output logic          erro,
  output logic [AW:0]   total,
  output estado_t       estado_dbg
);

  // Word count at which memory is full.
  localparam logic [AW:0] TOTAL_CHEIO = (AW+1)'(PROF);

  estado_t       estado_q;
  logic          campo_pronto_q;
  logic          instr_valido_q;
  logic [31:0]   instrucao_q;
  logic [AW-1:0] endereco_q;
  logic [AW:0]   total_q;
  logic          cheio_q;

  logic [31:0]   palavra;
  logic          aceita;     // presented field set is legal
  logic [AW:0]   total_inc;

  codifica_campos u_codifica (
    .formato_i  (formato),
    .op_code_i  (Op_code),
    .rs_i       (Register_rs),
    .rt_i       (Register_rt),
    .rd_i       (Register_rd),
    .shamt_i    (Shamt),
    .funct_i    (Funct),
    .endereco_i (Endereco),
    .alvo_i     (Alvo),
    .palavra_o  (palavra)
  );

`ifdef FORMATO_CHECK_EN
  logic erro_q;
  assign aceita = campos_aceitos(formato, Op_code);
`else
  assign aceita = 1'b1;
`endif

  assign total_inc = total_q + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      // Reset wins over both handshakes: a pending word is simply dropped.
      estado_q       <= OCIOSO;
      campo_pronto_q <= 1'b1;
      instr_valido_q <= 1'b0;
      instrucao_q    <= '0;
      endereco_q     <= '0;
      total_q        <= '0;
      cheio_q        <= 1'b0;
`ifdef FORMATO_CHECK_EN
      erro_q         <= 1'b0;
`endif
    end else begin
`ifdef FORMATO_CHECK_EN
      erro_q <= 1'b0;
`endif
      case (estado_q)
        OCIOSO: begin
          // campo_pronto is 1 throughout OCIOSO, so valid alone completes
          // the field handshake here.
          if (campo_valido && aceita) begin
            instrucao_q    <= palavra;
            instr_valido_q <= 1'b1;
            campo_pronto_q <= 1'b0;
            estado_q       <= ESCREVE;
          end
`ifdef FORMATO_CHECK_EN
          if (campo_valido && !aceita) begin
            erro_q <= 1'b1;
          end
`endif
        end

        ESCREVE: begin
          if (instr_pronto) begin
            instr_valido_q <= 1'b0;
            // Address wraps to 0 naturally once PROF words are written.
            endereco_q     <= endereco_q + 1'b1;
            total_q        <= total_inc;
            if (total_inc == TOTAL_CHEIO) begin
              cheio_q  <= 1'b1;
              estado_q <= CHEIO;
            end else begin
              campo_pronto_q <= 1'b1;
              estado_q       <= OCIOSO;
            end
          end
        end

        CHEIO: begin
          // Parked: all outputs hold until reset.
        end

        default: begin
          // Unreachable encoding: fall back to idle without writing.
          estado_q       <= OCIOSO;
          campo_pronto_q <= 1'b1;
          instr_valido_q <= 1'b0;
        end
      endcase
    end
  end

  assign campo_pronto   = campo_pronto_q;
  assign instr_valido   = instr_valido_q;
  assign instrucao      = instrucao_q;
  assign instr_endereco = endereco_q;
  assign total          = total_q;
  assign cheio          = cheio_q;
  assign estado_dbg     = estado_q;
`ifdef FORMATO_CHECK_EN
  assign erro = erro_q;
`else
  assign erro = 1'b0;
`endif

endmodule

// File: tb/tb_grava_instrucao.sv
// -----------------------------------------------------------------------------
// tb_grava_instrucao
//   Bench for grava_instrucao with PROF=4. A behavioural model tracks the
//   pending word, the write count and the full flag; a compare process checks
//   every DUT output against it on each falling edge, and a scoreboard queue
//   holds the (address, word) pairs the model expects memory to receive.
//   Directed sequences pin literal values; a randomized phase follows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_grava_instrucao;
  import instrucao_pkg::*;

  localparam int PROF = 4;
  localparam int AW   = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic          campo_valido;
  logic          campo_pronto;
  logic [1:0]    formato;
  logic [5:0]    Op_code;
  logic [4:0]    Register_rs;
  logic [4:0]    Register_rt;
  logic [4:0]    Register_rd;
  logic [4:0]    Shamt;
  logic [5:0]    Funct;
  logic [15:0]   Endereco;
  logic [25:0]   Alvo;
  logic          instr_valido;
  logic          instr_pronto;
  logic [31:0]   instrucao;
  logic [AW-1:0] instr_endereco;
  logic          cheio;
  logic          erro;
  logic [AW:0]   total;
  estado_t       estado_dbg;

  grava_instrucao #(.PROF(PROF), .AW(AW)) dut (
    .clock          (clock),
    .reset          (reset),
    .campo_valido   (campo_valido),
    .campo_pronto   (campo_pronto),
    .formato        (formato),
    .Op_code        (Op_code),
    .Register_rs    (Register_rs),
    .Register_rt    (Register_rt),
    .Register_rd    (Register_rd),
    .Shamt          (Shamt),
    .Funct          (Funct),
    .Endereco       (Endereco),
    .Alvo           (Alvo),
    .instr_valido   (instr_valido),
    .instr_pronto   (instr_pronto),
    .instrucao      (instrucao),
    .instr_endereco (instr_endereco),
    .cheio          (cheio),
    .erro           (erro),
    .total          (total),
    .estado_dbg     (estado_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit run_cmp  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_pack(input logic [1:0] f, input logic [5:0] op,
                                           input logic [4:0] s, input logic [4:0] t,
                                           input logic [4:0] d, input logic [4:0] sh,
                                           input logic [5:0] fn, input logic [15:0] im,
                                           input logic [25:0] al);
    longint w;
    longint opl;
    opl = longint'(op) * 64'd67108864;  // op * 2^26
    case (f)
      2'b00:   w = opl + longint'(s) * 2097152 + longint'(t) * 65536
                   + longint'(d) * 2048 + longint'(sh) * 64 + longint'(fn);
      2'b10:   w = opl + longint'(al);
      default: w = opl + longint'(s) * 2097152 + longint'(t) * 65536 + longint'(im);
    endcase
    return w[31:0];
  endfunction

  function automatic bit rejeita(input logic [1:0] f, input logic [5:0] op);
`ifdef FORMATO_CHECK_EN
    return (f == 2'b11) || (f == 2'b00 && op != 6'd0);
`else
    return (f == 2'b11) && (op == 6'd0) && 1'b0;
`endif
  endfunction

  bit          m_pend = 1'b0;   // a word is waiting for memory
  bit          m_full = 1'b0;
  bit          m_erro = 1'b0;
  logic [31:0] m_word = '0;
  int          m_addr = 0;
  int          m_total = 0;
  logic [63:0] exp_q[$];        // {address, word} expected at memory

  always @(posedge clock) begin
    if (reset) begin
      m_pend  <= 1'b0;
      m_full  <= 1'b0;
      m_erro  <= 1'b0;
      m_word  <= '0;
      m_addr  <= 0;
      m_total <= 0;
      exp_q.delete();
    end else begin
      m_erro <= 1'b0;
      if (m_pend) begin
        if (instr_pronto) begin
          m_pend  <= 1'b0;
          m_total <= m_total + 1;
          m_addr  <= (m_addr + 1) % PROF;
          if (m_total + 1 == PROF) m_full <= 1'b1;
        end
      end else if (!m_full && campo_valido) begin
        if (rejeita(formato, Op_code)) begin
          m_erro <= 1'b1;
        end else begin
          m_pend <= 1'b1;
          m_word <= ref_pack(formato, Op_code, Register_rs, Register_rt, Register_rd,
                             Shamt, Funct, Endereco, Alvo);
          exp_q.push_back({32'(m_addr), ref_pack(formato, Op_code, Register_rs, Register_rt,
                                                 Register_rd, Shamt, Funct, Endereco, Alvo)});
        end
      end
    end
  end

  // ---------------- compare process + scoreboard ----------------
  always @(negedge clock) begin
    if (run_cmp) begin
      check("campo_pronto", campo_pronto, !m_pend && !m_full);
      check("instr_valido", instr_valido, m_pend);
      check("instrucao", instrucao, m_word);
      check("instr_endereco", instr_endereco, m_addr);
      check("total", total, m_total);
      check("cheio", cheio, m_full);
      check("erro", erro, m_erro);
      if (instr_valido && instr_pronto && !reset) begin
        check("sb_expected_write", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0)
          check("sb_write", {32'(instr_endereco), instrucao}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_campos(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
                            input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                            input logic [5:0] fn, input logic [15:0] im, input logic [25:0] al);
    formato = f; Op_code = op; Register_rs = s; Register_rt = t; Register_rd = d;
    Shamt = sh; Funct = fn; Endereco = im; Alvo = al;
  endtask

  task automatic envia(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                       input logic [5:0] fn, input logic [15:0] im, input logic [25:0] al);
    set_campos(f, op, s, t, d, sh, fn, im, al);
    campo_valido = 1'b1;
    tick();
    campo_valido = 1'b0;
  endtask

  task automatic escreve();
    instr_pronto = 1'b1;
    tick();
    instr_pronto = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_campo_pronto"}, campo_pronto, 1'b1);
    check({tag, "_instr_valido"}, instr_valido, 1'b0);
    check({tag, "_instrucao"}, instrucao, 32'h0);
    check({tag, "_endereco"}, instr_endereco, 0);
    check({tag, "_total"}, total, 0);
    check({tag, "_cheio"}, cheio, 1'b0);
    check({tag, "_erro"}, erro, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    campo_valido = 1'b0;
    instr_pronto = 1'b0;
    set_campos(2'b00, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    tick();
    tick();
    reset = 1'b0;
    run_cmp = 1'b1;
    check_reset_values("rst");

    // R add $3,$1,$2
    envia(2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    check("radd_valido", instr_valido, 1'b1);
    check("radd_word", instrucao, 32'h00221820);
    check("radd_model", m_word, 32'h00221820);
    check("radd_addr", instr_endereco, 0);
    escreve();
    check("radd_total", total, 1);
    check("radd_valido_low", instr_valido, 1'b0);

    // I addi $2,$1,5
    envia(2'b01, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0);
    check("addi_word", instrucao, 32'h20220005);
    check("addi_addr", instr_endereco, 1);
    escreve();
    check("addi_total", total, 2);

    // J with memory stalled for 3 cycles; new fields presented meanwhile
    envia(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000010);
    check("j_word", instrucao, 32'h08000010);
    check("j_model", m_word, 32'h08000010);
    set_campos(2'b00, 6'h00, 5'd9, 5'd9, 5'd9, 5'd1, 6'h21, 16'h0, 26'h0);
    campo_valido = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("j_hold_word", instrucao, 32'h08000010);
      check("j_hold_addr", instr_endereco, 2);
      check("j_hold_pronto", campo_pronto, 1'b0);
      check("j_hold_valido", instr_valido, 1'b1);
    end
    campo_valido = 1'b0;
    escreve();
    check("j_total", total, 3);

    // Fourth write fills PROF=4
    envia(2'b00, 6'h00, 5'd4, 5'd5, 5'd6, 5'd7, 6'h2a, 16'h0, 26'h0);
    check("fill_word", instrucao, 32'h008531EA);
    check("fill_addr", instr_endereco, 3);
    escreve();
    check("fill_cheio", cheio, 1'b1);
    check("fill_total", total, 4);
    check("fill_addr_wrap", instr_endereco, 0);
    campo_valido = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_pronto", campo_pronto, 1'b0);
      check("full_valido", instr_valido, 1'b0);
      check("full_total", total, 4);
    end
    campo_valido = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("fill_rst");

    // Reset while a word is pending
    envia(2'b01, 6'h08, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h00ff, 26'h0);
    check("mid_valido", instr_valido, 1'b1);
    instr_pronto = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    instr_pronto = 1'b0;
    check("mid_valido_low", instr_valido, 1'b0);
    check("mid_total", total, 0);
    tick();
    check("mid_total_after", total, 0);

    // Reserved format
    envia(2'b11, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0);
`ifdef FORMATO_CHECK_EN
    check("inv_erro", erro, 1'b1);
    check("inv_total", total, 0);
    check("inv_valido", instr_valido, 1'b0);
    tick();
    check("inv_erro_pulse", erro, 1'b0);
    envia(2'b00, 6'h01, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    check("rop_erro", erro, 1'b1);
    check("rop_pronto", campo_pronto, 1'b1);
    tick();
    check("rop_erro_pulse", erro, 1'b0);
`else
    check("inv_valido", instr_valido, 1'b1);
    check("inv_word", instrucao, 32'h20221234);
    check("inv_erro", erro, 1'b0);
    escreve();
    check("inv_total", total, 1);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Randomized phase
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      campo_valido = 1'($urandom_range(0, 1));
      set_campos(2'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1) ? 6'd0 : 6'($urandom_range(0, 63)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 6'($urandom_range(0, 63)), 16'($urandom_range(0, 65535)),
                 26'($urandom_range(0, 32'h03ff_ffff)));
      instr_pronto = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Drain: every word the model expects must have reached memory
    reset = 1'b0;
    campo_valido = 1'b0;
    instr_pronto = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("sb_drain", exp_q.size(), 0);
    instr_pronto = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
